pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 6-stage MIPS core; it supersedes the hand-written per-stage registers.
- Carries a payload (data and control fields) from one stage to the next and handles the stall vector, flush and bubble insertion.
- Provides a loop-back carry channel that holds multi-cycle state (e.g. madd/msub partial HI/LO and cycle count) while the stage is stalled.
- Adds saturating stall/bubble performance counters for profiling.

Parameters:
- DATA_W, 32, width of data payload (zeroed on bubble/flush).
- CTRL_W, 8, width of control payload (write enables, dest addr; zeroed on bubble/flush).
- CARRY_W, 66, width of multi-cycle carry state (64 HI/LO temp + 2 cnt).
- STALL_W, 6, width of the pipeline stall vector.
- STAGE, 3, index of this register's upstream stall bit; STAGE+1 is downstream.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  per-stage stall vector, 1 = Stop.
- flush  in  1  squash stage contents (exception/branch redirect).
- perf_clr  in  1  synchronous clear of performance counters.
- in_valid  in  1  upstream instruction valid.
- in_ctrl  in  CTRL_W  upstream control fields.
- in_data  in  DATA_W  upstream data fields.
- carry_i  in  CARRY_W  multi-cycle state from upstream stage logic.
- out_valid  out  1  registered valid.
- out_ctrl  out  CTRL_W  registered control.
- out_data  out  DATA_W  registered data.
- carry_o  out  CARRY_W  registered carry state, fed back to upstream stage.
- stall_cnt  out  CNT_W  cycles with stall[STAGE]=1.
- bubble_cnt  out  CNT_W  bubbles inserted.

Behaviour:
- Terms: up_stop = stall[STAGE]. dn_stop = stall[STAGE+1]; if STAGE == STALL_W-1, dn_stop = 0. Evaluated on every posedge clk.
- Mode priority, highest first: rst > flush > bubble > advance > hold.
  - rst: out_valid/out_ctrl/out_data/carry_o = 0; stall_cnt = bubble_cnt = 0.
  - flush: out_valid/out_ctrl/out_data = 0; carry_o = 0. Counters unchanged.
  - bubble (up_stop=1, dn_stop=0): out_valid/out_ctrl/out_data = 0; carry_o <= carry_i.
  - advance (up_stop=0): out_* <= in_*; carry_o = 0.
  - hold (up_stop=1, dn_stop=1): out_valid/out_ctrl/out_data keep their value; carry_o <= carry_i.
- Latency: 1 cycle in to out on advance. No combinational in-to-out path.
- Carry semantics: the carry value is only meaningful while stalled. It is cleared whenever the instruction leaves (advance) or is squashed (flush).
- stall_cnt:
  - +1 each cycle up_stop=1 and not rst/flush.
  - Saturates at 2^CNT_W-1 and never wraps.
- bubble_cnt:
  - +1 each bubble cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
- perf_clr:
  - Sets both counters to 0 next cycle.
  - Beats a simultaneous increment (result 0).
  - rst still has priority.
  - Does not affect the payload.
- Simultaneous flush + stall: flush wins, carry cleared, no counter increment.
- Reset mid-multi-cycle-op: carry_o = 0, and the upstream op restarts from cnt=0.
- Stall vector is trusted monotonic (stall[k]=1 implies stall[j]=1 for j<k). Behaviour is defined per the table above even if it is violated.
- Elaboration-time check: STAGE < STALL_W; otherwise $error.

Decomposition:
- Shared package cpu_pipe_pkg:
  - Stop/NoStop.
  - ZeroWord.
  - NOPRegAddr.
  - WriteEnable/WriteDisable.
  - default CARRY_W breakdown constants (HILO_TMP_W=64, MCYC_CNT_W=2).
- Sub-module sat_counter (params W; ports clk, rst, clr, inc, q), instantiated twice for the performance counters.
- Mode decode stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with in_data=32'hDEADBEEF, in_valid=1 -> all outputs 0; counters 0.
- Advance: stall=6'b000000, in_data=32'h12345678, in_ctrl=8'hA5, in_valid=1 -> next cycle out_data=32'h12345678, out_ctrl=8'hA5, out_valid=1, carry_o=0.
- Bubble with carry:
  - Stimulus: stall=6'b001111 (STAGE=3, bit4=0), carry_i=66'h1_0000_0002_0000_0003.
  - Required: out_valid=0, out_ctrl=0, out_data=0, carry_o=carry_i, bubble_cnt=1, stall_cnt=1.
  - Then stall=0 -> carry_o=0, payload loads.
- Hold: preload out_data=32'h0BADF00D, then stall=6'b011111 for 3 cycles with changing in_data -> out_data stays 32'h0BADF00D, carry_o tracks carry_i, stall_cnt=3, bubble_cnt=0.
- Flush vs stall: flush=1 with stall=6'b001111, carry_i nonzero -> all outputs 0, carry_o=0, counters unchanged.
- Counter saturation/clear:
  - CNT_W=4, hold stall for 20 cycles -> stall_cnt=4'hF.
  - perf_clr=1 while stalled -> stall_cnt=0 next cycle.
  - Run at STAGE=5 -> dn_stop treated as 0, so every stall cycle is a bubble.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and the inter-stage register mode encoding.
// Width constants describe the default layout of the multi-cycle carry channel.
package cpu_pipe_pkg;

  localparam logic Stop    = 1'b1;
  localparam logic NoStop  = 1'b0;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Carry layout: {hilo_tmp[63:0], mcyc_cnt[1:0]}
  localparam int HILO_TMP_W = 64;
  localparam int MCYC_CNT_W = 2;

  typedef enum logic [1:0] {
    MODE_FLUSH,
    MODE_BUBBLE,
    MODE_ADVANCE,
    MODE_HOLD
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; rst and clr both beat an increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: 1-cycle payload latency, flush/bubble/hold from the stall vector,
// loop-back carry state kept only while stalled, saturating stall/bubble profiling counters.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 8,
  parameter int CARRY_W = HILO_TMP_W + MCYC_CNT_W,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               perf_clr,
  input  logic               in_valid,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CARRY_W-1:0] carry_i,
  output logic               out_valid,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [CARRY_W-1:0] carry_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  if (STAGE >= STALL_W) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE (%0d) must be below STALL_W (%0d)", STAGE, STALL_W);
  end

  logic  up_stop;
  logic  dn_stop;
  mode_e mode;

  assign up_stop = stall[STAGE];

  // The last stage has nothing downstream that can stop it.
  if (STAGE == STALL_W - 1) begin : g_last_stage
    assign dn_stop = NoStop;
  end else begin : g_mid_stage
    assign dn_stop = stall[STAGE+1];
  end

  always_comb begin
    mode = MODE_HOLD;
    if (flush) begin
      mode = MODE_FLUSH;
    end else if (up_stop == NoStop) begin
      mode = MODE_ADVANCE;
    end else if (dn_stop == NoStop) begin
      mode = MODE_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
      carry_o   <= '0;
    end else begin
      unique case (mode)
        MODE_FLUSH: begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          out_data  <= '0;
          carry_o   <= '0;
        end
        MODE_BUBBLE: begin
          out_valid <= 1'b0;
          out_ctrl  <= '0;
          out_data  <= '0;
          carry_o   <= carry_i;
        end
        MODE_ADVANCE: begin
          out_valid <= in_valid;
          out_ctrl  <= in_ctrl;
          out_data  <= in_data;
          carry_o   <= '0;
        end
        default: begin
          carry_o <= carry_i;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (up_stop & ~flush),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (mode == MODE_BUBBLE),
    .q   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, CNT_W=4, STAGE=5) against a behavioural model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        perf_clr;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic [65:0] carry_i;

  logic        o_valid[3];
  logic [7:0]  o_ctrl[3];
  logic [31:0] o_data[3];
  logic [65:0] o_carry[3];
  logic [15:0] o_scnt[3];
  logic [15:0] o_bcnt[3];
  logic [3:0]  sc1, bc1;

  int total = 0;
  int bad = 0;

  // Reference model state, one slot per instance
  logic        m_valid[3];
  logic [7:0]  m_ctrl[3];
  logic [31:0] m_data[3];
  logic [65:0] m_carry[3];
  int          m_sc[3];
  int          m_bc[3];
  int          stg[3]  = '{3, 3, 5};
  int          cmax[3] = '{65535, 15, 65535};

  always #5 clk = ~clk;

  pipe_stage_reg u0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .carry_i(carry_i),
    .out_valid(o_valid[0]), .out_ctrl(o_ctrl[0]), .out_data(o_data[0]), .carry_o(o_carry[0]),
    .stall_cnt(o_scnt[0]), .bubble_cnt(o_bcnt[0])
  );

  pipe_stage_reg #(.CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .carry_i(carry_i),
    .out_valid(o_valid[1]), .out_ctrl(o_ctrl[1]), .out_data(o_data[1]), .carry_o(o_carry[1]),
    .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  assign o_scnt[1] = {12'd0, sc1};
  assign o_bcnt[1] = {12'd0, bc1};

  pipe_stage_reg #(.STAGE(5)) u2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .perf_clr(perf_clr),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .carry_i(carry_i),
    .out_valid(o_valid[2]), .out_ctrl(o_ctrl[2]), .out_data(o_data[2]), .carry_o(o_carry[2]),
    .stall_cnt(o_scnt[2]), .bubble_cnt(o_bcnt[2])
  );

  function automatic int sat_add(int v, int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Behavioural reference: what each stage register should hold after this edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit up, dn;
      up = stall[stg[i]];
      dn = (stg[i] + 1 < 6) ? stall[stg[i] + 1] : 1'b0;
      if (rst) begin
        m_valid[i] = 0; m_ctrl[i] = 0; m_data[i] = 0; m_carry[i] = 0;
        m_sc[i] = 0; m_bc[i] = 0;
      end else begin
        if (flush) begin
          m_valid[i] = 0; m_ctrl[i] = 0; m_data[i] = 0; m_carry[i] = 0;
        end else if (!up) begin
          m_valid[i] = in_valid; m_ctrl[i] = in_ctrl; m_data[i] = in_data; m_carry[i] = 0;
        end else begin
          if (!dn) begin
            m_valid[i] = 0; m_ctrl[i] = 0; m_data[i] = 0;
          end
          m_carry[i] = carry_i;
        end
        if (perf_clr) begin
          m_sc[i] = 0; m_bc[i] = 0;
        end else begin
          if (!flush && up) m_sc[i] = sat_add(m_sc[i], cmax[i]);
          if (!flush && up && !dn) m_bc[i] = sat_add(m_bc[i], cmax[i]);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; perf_clr = 0;
    in_valid = 1; in_ctrl = 8'hFF; in_data = 32'hDEADBEEF; carry_i = 66'h3_FFFF_FFFF_FFFF_FFFF;
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({o_valid[i], o_ctrl[i], o_data[i], o_carry[i]} !== '0) begin
        bad++; $display("FAIL reset_payload[%0d]: got v=%b c=%h d=%h k=%h want all 0",
                        i, o_valid[i], o_ctrl[i], o_data[i], o_carry[i]);
      end
      total++;
      if (o_scnt[i] !== 16'd0 || o_bcnt[i] !== 16'd0) begin
        bad++; $display("FAIL reset_counters[%0d]: got s=%0d b=%0d want 0 0", i, o_scnt[i], o_bcnt[i]);
      end
    end
    rst = 0;
  endtask

  task automatic test_advance();
    stall = 6'b000000; in_data = 32'h12345678; in_ctrl = 8'hA5; in_valid = 1;
    carry_i = 66'h2_AAAA_5555_AAAA_5555;
    cycle();
    total++;
    if (o_data[0] !== 32'h12345678 || o_ctrl[0] !== 8'hA5 || o_valid[0] !== 1'b1) begin
      bad++; $display("FAIL advance_payload: got v=%b c=%h d=%h want 1 a5 12345678",
                      o_valid[0], o_ctrl[0], o_data[0]);
    end
    total++;
    if (o_carry[0] !== 66'h0) begin
      bad++; $display("FAIL advance_carry: got %h want 0", o_carry[0]);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001111; carry_i = 66'h1_0000_0002_0000_0003;
    in_data = 32'h11112222; in_ctrl = 8'h3C;
    cycle();
    total++;
    if (o_valid[0] !== 1'b0 || o_ctrl[0] !== 8'h00 || o_data[0] !== 32'h0) begin
      bad++; $display("FAIL bubble_payload: got v=%b c=%h d=%h want 0 0 0", o_valid[0], o_ctrl[0], o_data[0]);
    end
    total++;
    if (o_carry[0] !== 66'h1_0000_0002_0000_0003) begin
      bad++; $display("FAIL bubble_carry: got %h want 10000000200000003", o_carry[0]);
    end
    total++;
    if (o_bcnt[0] !== 16'd1 || o_scnt[0] !== 16'd1) begin
      bad++; $display("FAIL bubble_counters: got s=%0d b=%0d want 1 1", o_scnt[0], o_bcnt[0]);
    end
    stall = 6'b000000; in_data = 32'hCAFE0001; in_ctrl = 8'h5A;
    cycle();
    total++;
    if (o_carry[0] !== 66'h0 || o_data[0] !== 32'hCAFE0001 || o_ctrl[0] !== 8'h5A) begin
      bad++; $display("FAIL bubble_release: got k=%h d=%h c=%h want 0 cafe0001 5a",
                      o_carry[0], o_data[0], o_ctrl[0]);
    end
  endtask

  task automatic test_hold();
    stall = 6'b000000; in_data = 32'h0BADF00D; in_ctrl = 8'h77; perf_clr = 1;
    cycle();
    perf_clr = 0;
    total++;
    if (o_data[0] !== 32'h0BADF00D || o_scnt[0] !== 16'd0 || o_bcnt[0] !== 16'd0) begin
      bad++; $display("FAIL hold_preload: got d=%h s=%0d b=%0d want 0badf00d 0 0",
                      o_data[0], o_scnt[0], o_bcnt[0]);
    end
    for (int k = 0; k < 3; k++) begin
      logic [65:0] c;
      c = {2'($urandom), $urandom, $urandom};
      stall = 6'b011111; in_data = $urandom; carry_i = c;
      cycle();
      total++;
      if (o_data[0] !== 32'h0BADF00D || o_ctrl[0] !== 8'h77 || o_valid[0] !== 1'b1) begin
        bad++; $display("FAIL hold_payload[%0d]: got v=%b c=%h d=%h want 1 77 0badf00d",
                        k, o_valid[0], o_ctrl[0], o_data[0]);
      end
      total++;
      if (o_carry[0] !== c) begin
        bad++; $display("FAIL hold_carry[%0d]: got %h want %h", k, o_carry[0], c);
      end
    end
    total++;
    if (o_scnt[0] !== 16'd3 || o_bcnt[0] !== 16'd0) begin
      bad++; $display("FAIL hold_counters: got s=%0d b=%0d want 3 0", o_scnt[0], o_bcnt[0]);
    end
  endtask

  task automatic test_flush();
    stall = 6'b001111; flush = 1; carry_i = 66'h3_1234_5678_9ABC_DEF0;
    cycle();
    flush = 0;
    total++;
    if ({o_valid[0], o_ctrl[0], o_data[0], o_carry[0]} !== '0) begin
      bad++; $display("FAIL flush_outputs: got v=%b c=%h d=%h k=%h want all 0",
                      o_valid[0], o_ctrl[0], o_data[0], o_carry[0]);
    end
    total++;
    if (o_scnt[0] !== 16'd3 || o_bcnt[0] !== 16'd0) begin
      bad++; $display("FAIL flush_counters: got s=%0d b=%0d want 3 0", o_scnt[0], o_bcnt[0]);
    end
  endtask

  task automatic test_saturation();
    stall = 6'b011111;
    for (int k = 0; k < 20; k++) cycle();
    total++;
    if (o_scnt[1] !== 16'h000F) begin
      bad++; $display("FAIL sat_small: got %h want f", o_scnt[1]);
    end
    total++;
    if (o_scnt[0] !== 16'd23) begin
      bad++; $display("FAIL sat_wide: got %0d want 23", o_scnt[0]);
    end
    perf_clr = 1;
    cycle();
    perf_clr = 0;
    total++;
    if (o_scnt[1] !== 16'd0 || o_scnt[0] !== 16'd0) begin
      bad++; $display("FAIL perf_clr: got s1=%0d s0=%0d want 0 0", o_scnt[1], o_scnt[0]);
    end
  endtask

  task automatic test_last_stage();
    stall = 6'b000000; perf_clr = 1; in_valid = 1; in_data = 32'h55AA55AA;
    cycle();
    perf_clr = 0;
    for (int k = 0; k < 5; k++) begin
      stall = 6'b111111; carry_i = {2'($urandom), $urandom, $urandom};
      cycle();
    end
    total++;
    if (o_bcnt[2] !== 16'd5 || o_scnt[2] !== 16'd5) begin
      bad++; $display("FAIL last_stage_counters: got s=%0d b=%0d want 5 5", o_scnt[2], o_bcnt[2]);
    end
    total++;
    if (o_valid[2] !== 1'b0 || o_carry[2] !== carry_i) begin
      bad++; $display("FAIL last_stage_bubble: got v=%b k=%h want 0 %h", o_valid[2], o_carry[2], carry_i);
    end
    total++;
    if (o_bcnt[0] !== 16'd0 || o_data[0] !== 32'h55AA55AA) begin
      bad++; $display("FAIL mid_stage_hold: got b=%0d d=%h want 0 55aa55aa", o_bcnt[0], o_data[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 60) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      perf_clr = ($urandom_range(0, 40) == 0);
      // Mostly monotonic stall vectors, occasionally arbitrary ones
      if ($urandom_range(0, 3) == 0) stall = 6'($urandom);
      else stall = 6'((7'd1 << $urandom_range(0, 6)) - 7'd1);
      in_valid = 1'($urandom);
      in_ctrl  = 8'($urandom);
      in_data  = $urandom;
      carry_i  = {2'($urandom), $urandom, $urandom};
      cycle();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (o_valid[i] !== m_valid[i] || o_ctrl[i] !== m_ctrl[i] || o_data[i] !== m_data[i]) begin
          bad++; $display("FAIL rand_payload[%0d] cyc %0d: got v=%b c=%h d=%h want v=%b c=%h d=%h",
                          i, n, o_valid[i], o_ctrl[i], o_data[i], m_valid[i], m_ctrl[i], m_data[i]);
        end
        total++;
        if (o_carry[i] !== m_carry[i]) begin
          bad++; $display("FAIL rand_carry[%0d] cyc %0d: got %h want %h", i, n, o_carry[i], m_carry[i]);
        end
        total++;
        if (o_scnt[i] !== 16'(m_sc[i]) || o_bcnt[i] !== 16'(m_bc[i])) begin
          bad++; $display("FAIL rand_counters[%0d] cyc %0d: got s=%0d b=%0d want s=%0d b=%0d",
                          i, n, o_scnt[i], o_bcnt[i], m_sc[i], m_bc[i]);
        end
      end
    end
    rst = 0; flush = 0; perf_clr = 0;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturation();
    test_last_stage();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
